mdu_scheduler: RTL and testbench
================================

Name: mdu_scheduler

Overview:
Issue/completion sequencer for the execute stage's multicycle units: multiplier, divider and FPU. It accepts one classified op from ID/EX and pulses the start of the selected unit. It then stalls the pipeline until the unit reports ready and emits a single writeback-valid pulse with the latched destination. It also supports flush, freeze (debug/memory hold), a timeout watchdog and a stall-cycle counter.

Parameters:
TIMEOUT, 64, maximum WAIT cycles before the watchdog aborts the op (must be >= 2)
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
hold  in  1  pipeline freeze (dbg | mem_hold)
flush  in  1  squash in-flight op (branch/trap)
issue_valid  in  1  ID/EX holds a valid instruction
issue_class  in  2  00 ALU (not handled), 01 MUL, 10 DIV, 11 FPU
issue_rd  in  5  destination register
issue_regwrite  in  1  op writes rd
mul_ready  in  1  multiplier result valid
div_ready  in  1  divider result valid
fpu_stall  in  1  FPU busy (low = result valid)
mul_start  out  1  one-cycle start pulse
div_start  out  1  one-cycle start pulse
fpu_start  out  1  one-cycle start pulse
ex_stall  out  1  hold ID/EX and earlier stages
wb_valid  out  1  one-cycle completion pulse
wb_class  out  2  class of completing op (EX_MEM result mux select)
wb_rd  out  5  latched rd
wb_regwrite  out  1  latched regwrite; forced 0 on timeout
busy_valid  out  1  op in flight (hazard detection)
busy_rd  out  5  rd of in-flight op
timeout_err  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  saturating stall counter

Behaviour:
- Reset (Rst_n=0, async): state=IDLE, latched class/rd/regwrite=0, wait counter=0, timeout_err=0, stall_cycles=0. All outputs are 0.
- States: IDLE, WAIT_MUL, WAIT_DIV, WAIT_FPU, DONE.
- Priority: reset > hold > flush > ready/timeout > issue.
- IDLE, when issue_valid & class!=00 & !hold & !flush:
  - Combinationally assert the matching *_start and ex_stall in that same cycle.
  - Latch class/rd/regwrite and go to WAIT_x at the next edge.
  - Class 00: no start, no stall, state stays IDLE.
- WAIT_x:
  - ex_stall=1 and the wait counter increments each cycle.
  - Ready is the unit's ready signal (for FPU: !fpu_stall), sampled from the first WAIT cycle onward. Ready in the issue cycle is ignored.
  - Ready=1 → DONE; ex_stall stays 1 during that ready cycle.
  - Counter reaching TIMEOUT-1 without ready → set timeout_err, clear latched regwrite, go to DONE.
- DONE:
  - ex_stall=0, wb_valid=1, wb_class/wb_rd/wb_regwrite driven from latches.
  - issue_valid is ignored because ID/EX still holds the completing op.
  - Next state is IDLE; there is no back-to-back issue in DONE.
- Back-to-back: a new multicycle op can start in the IDLE cycle after DONE. Minimum issue spacing is 3 cycles plus unit latency.
- hold=1: state, latches, counters and stall_cycles are frozen. Start pulses are suppressed. Combinational outputs reflect the frozen state; wb_valid held in DONE is not a repeat completion, and consumers also gate on hold.
- flush=1 (not hold):
  - Any state → IDLE at the next edge with the wait counter cleared.
  - Same-cycle start and wb_valid are suppressed.
  - flush wins over a ready arriving in the same cycle.
- busy_valid=1 in WAIT_* and DONE; busy_rd = latched rd. Both are 0 in IDLE.
- stall_cycles increments when ex_stall & !hold and saturates at all-ones. It does not wrap.
- wb_class, wb_rd and wb_regwrite are 0 whenever wb_valid=0.
- Reset mid-WAIT returns immediately to IDLE. No pulses are emitted afterward.

Test Plan:
- MUL issue, rd=5, regwrite=1; mul_ready asserted 3 cycles after start → mul_start for 1 cycle, ex_stall for 4 cycles, then wb_valid=1 with wb_class=01, wb_rd=5, wb_regwrite=1 for exactly 1 cycle; stall_cycles=4.
- DIV issue; flush asserted on the 2nd WAIT cycle together with div_ready → no wb_valid, state IDLE, busy_valid=0 on the next cycle.
- FPU issue with hold asserted for 5 cycles mid-WAIT and fpu_stall dropping during the hold → state stays frozen, no completion until hold drops; completion follows on the first unheld cycle.
- Divider never ready, TIMEOUT=8 → DONE after 8 WAIT cycles, wb_valid=1, wb_regwrite=0, timeout_err=1 and still 1 after 100 further cycles.
- Two consecutive MUL ops with issue_valid held continuously → exactly two mul_start pulses and two wb_valid pulses; no reissue in DONE.
- Rst_n driven low asynchronously mid-WAIT_FPU, between clock edges → all outputs 0 immediately; after release, an ALU-class issue produces no stall.

Source files
------------

// File: rtl/mdu_scheduler_if.sv
// rtl/mdu_scheduler_if.sv - issue, unit handshake and writeback bundle for mdu_scheduler
interface mdu_scheduler_if #(
    parameter int CNT_W = 32
);
    logic             hold;
    logic             flush;
    logic             issue_valid;
    logic [1:0]       issue_class;
    logic [4:0]       issue_rd;
    logic             issue_regwrite;
    logic             mul_ready;
    logic             div_ready;
    logic             fpu_stall;
    logic             mul_start;
    logic             div_start;
    logic             fpu_start;
    logic             ex_stall;
    logic             wb_valid;
    logic [1:0]       wb_class;
    logic [4:0]       wb_rd;
    logic             wb_regwrite;
    logic             busy_valid;
    logic [4:0]       busy_rd;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;

    modport slave (
        input  hold, flush, issue_valid, issue_class, issue_rd, issue_regwrite,
               mul_ready, div_ready, fpu_stall,
        output mul_start, div_start, fpu_start, ex_stall,
               wb_valid, wb_class, wb_rd, wb_regwrite,
               busy_valid, busy_rd, timeout_err, stall_cycles
    );

    modport master (
        output hold, flush, issue_valid, issue_class, issue_rd, issue_regwrite,
               mul_ready, div_ready, fpu_stall,
        input  mul_start, div_start, fpu_start, ex_stall,
               wb_valid, wb_class, wb_rd, wb_regwrite,
               busy_valid, busy_rd, timeout_err, stall_cycles
    );
endinterface

// File: rtl/mdu_scheduler.sv
// rtl/mdu_scheduler.sv - issue/completion sequencer for the MUL, DIV and FPU multicycle units
module mdu_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           Rst_n,
    mdu_scheduler_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MUL,
        S_WAIT_DIV,
        S_WAIT_FPU,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        cls_q, cls_nxt;
    logic [4:0]        rd_q, rd_nxt;
    logic              rw_q, rw_nxt;
    logic [WAIT_W-1:0] wait_q, wait_nxt;
    logic              terr_q, terr_nxt;
    logic [CNT_W-1:0]  stall_q;
    logic              launch, waiting, unit_ready;
    logic              mul_start, div_start, fpu_start, ex_stall, wb_valid;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= S_IDLE;
            cls_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            wait_q  <= '0;
            terr_q  <= 1'b0;
            stall_q <= '0;
        end else if (!bus.hold) begin
            state  <= state_nxt;
            cls_q  <= cls_nxt;
            rd_q   <= rd_nxt;
            rw_q   <= rw_nxt;
            wait_q <= wait_nxt;
            terr_q <= terr_nxt;
            if (ex_stall && stall_q != '1)
                stall_q <= stall_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        cls_nxt    = cls_q;
        rd_nxt     = rd_q;
        rw_nxt     = rw_q;
        wait_nxt   = wait_q;
        terr_nxt   = terr_q;
        mul_start  = 1'b0;
        div_start  = 1'b0;
        fpu_start  = 1'b0;
        ex_stall   = 1'b0;
        wb_valid   = 1'b0;
        // Rst_n gates the issue path so every output reads 0 while reset is held
        launch     = Rst_n && state == S_IDLE && bus.issue_valid && bus.issue_class != 2'b00
                     && !bus.hold && !bus.flush;
        waiting    = state == S_WAIT_MUL || state == S_WAIT_DIV || state == S_WAIT_FPU;
        unit_ready = (state == S_WAIT_MUL && bus.mul_ready) ||
                     (state == S_WAIT_DIV && bus.div_ready) ||
                     (state == S_WAIT_FPU && !bus.fpu_stall);

        if (launch) begin
            mul_start = bus.issue_class == 2'b01;
            div_start = bus.issue_class == 2'b10;
            fpu_start = bus.issue_class == 2'b11;
        end
        ex_stall = launch || waiting;
        wb_valid = state == S_DONE && !(bus.flush && !bus.hold);

        if (bus.flush) begin
            state_nxt = S_IDLE;
            wait_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        cls_nxt  = bus.issue_class;
                        rd_nxt   = bus.issue_rd;
                        rw_nxt   = bus.issue_regwrite;
                        wait_nxt = '0;
                        case (bus.issue_class)
                            2'b01:   state_nxt = S_WAIT_MUL;
                            2'b10:   state_nxt = S_WAIT_DIV;
                            default: state_nxt = S_WAIT_FPU;
                        endcase
                    end
                end
                S_WAIT_MUL, S_WAIT_DIV, S_WAIT_FPU: begin
                    if (unit_ready) begin
                        state_nxt = S_DONE;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        // abandon the op: completion still retires it, but without a register write
                        state_nxt = S_DONE;
                        terr_nxt  = 1'b1;
                        rw_nxt    = 1'b0;
                    end else begin
                        wait_nxt = wait_q + 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    wait_nxt  = '0;
                end
            endcase
        end
    end

    assign bus.mul_start    = mul_start;
    assign bus.div_start    = div_start;
    assign bus.fpu_start    = fpu_start;
    assign bus.ex_stall     = ex_stall;
    assign bus.wb_valid     = wb_valid;
    assign bus.wb_class     = wb_valid ? cls_q : 2'b00;
    assign bus.wb_rd        = wb_valid ? rd_q : 5'd0;
    assign bus.wb_regwrite  = wb_valid && rw_q;
    assign bus.busy_valid   = state != S_IDLE;
    assign bus.busy_rd      = state != S_IDLE ? rd_q : 5'd0;
    assign bus.timeout_err  = terr_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_mdu_scheduler.sv
// tb/tb_mdu_scheduler.sv - randomized and directed bench for mdu_scheduler against a behavioural model
module tb_mdu_scheduler;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 8;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    // model: an op is either outstanding (m_act) or retiring this cycle (m_fin)
    bit m_act, m_fin, m_terr;
    int m_cls, m_rd, m_rw, m_waited, m_stall;
    int n_mul_start, n_wb;

    always #5 clk = ~clk;

    mdu_scheduler_if #(.CNT_W(CNT_W)) bus ();
    mdu_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_fin = 0; m_terr = 0;
        m_cls = 0; m_rd = 0; m_rw = 0; m_waited = 0; m_stall = 0;
    endtask

    task automatic drive_idle();
        bus.hold = 0; bus.flush = 0; bus.issue_valid = 0; bus.issue_class = 0;
        bus.issue_rd = 0; bus.issue_regwrite = 0;
        bus.mul_ready = 0; bus.div_ready = 0; bus.fpu_stall = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_starts"}, {bus.mul_start, bus.div_start, bus.fpu_start}, 0);
        check({tag, "_stall"}, bus.ex_stall, 0);
        check({tag, "_wb"}, {bus.wb_valid, bus.wb_class, bus.wb_rd, bus.wb_regwrite}, 0);
        check({tag, "_busy"}, {bus.busy_valid, bus.busy_rd}, 0);
        check({tag, "_terr"}, bus.timeout_err, 0);
        check({tag, "_scnt"}, bus.stall_cycles, 0);
    endtask

    // one clock cycle: apply inputs, compare every output with the model, advance the model
    task automatic cyc(input bit h, input bit f, input bit iv, input int ic, input int rd,
                       input bit rw, input bit mr, input bit dr, input bit fs);
        bit go, e_stall, e_wb, e_busy, rdy;
        @(negedge clk);
        bus.hold = h; bus.flush = f; bus.issue_valid = iv; bus.issue_class = 2'(ic);
        bus.issue_rd = 5'(rd); bus.issue_regwrite = rw;
        bus.mul_ready = mr; bus.div_ready = dr; bus.fpu_stall = fs;
        #1;
        go      = !m_act && !m_fin && iv && ic != 0 && !h && !f;
        e_stall = go || m_act;
        e_wb    = m_fin && !(f && !h);
        e_busy  = m_act || m_fin;
        check("mul_start", bus.mul_start, go && ic == 1);
        check("div_start", bus.div_start, go && ic == 2);
        check("fpu_start", bus.fpu_start, go && ic == 3);
        check("ex_stall", bus.ex_stall, e_stall);
        check("wb_valid", bus.wb_valid, e_wb);
        check("wb_class", bus.wb_class, e_wb ? m_cls : 0);
        check("wb_rd", bus.wb_rd, e_wb ? m_rd : 0);
        check("wb_regwrite", bus.wb_regwrite, e_wb ? m_rw : 0);
        check("busy_valid", bus.busy_valid, e_busy);
        check("busy_rd", bus.busy_rd, e_busy ? m_rd : 0);
        check("timeout_err", bus.timeout_err, m_terr);
        check("stall_cycles", bus.stall_cycles, m_stall);
        n_mul_start += bus.mul_start;
        n_wb        += bus.wb_valid;
        if (!h) begin
            if (e_stall && m_stall < SAT) m_stall++;
            rdy = (m_cls == 1 && mr) || (m_cls == 2 && dr) || (m_cls == 3 && !fs);
            if (f) begin
                m_act = 0; m_fin = 0; m_waited = 0;
            end else if (m_fin) begin
                m_fin = 0;
            end else if (m_act) begin
                if (rdy) begin
                    m_act = 0; m_fin = 1;
                end else if (m_waited == TIMEOUT - 1) begin
                    m_act = 0; m_fin = 1; m_terr = 1; m_rw = 0;
                end else begin
                    m_waited++;
                end
            end else if (go) begin
                m_act = 1; m_waited = 0; m_cls = ic; m_rd = rd; m_rw = rw;
            end
        end
    endtask

    initial begin
        model_reset();
        drive_idle();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // MUL, ready three cycles after start
        cyc(0, 0, 1, 1, 5, 1, 0, 0, 1);
        cyc(0, 0, 1, 1, 5, 1, 0, 0, 1);
        cyc(0, 0, 1, 1, 5, 1, 0, 0, 1);
        cyc(0, 0, 1, 1, 5, 1, 1, 0, 1);
        cyc(0, 0, 1, 1, 5, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("mul_stall_count", bus.stall_cycles, 4);

        // DIV flushed on its second WAIT cycle while div_ready arrives
        cyc(0, 0, 1, 2, 9, 1, 0, 0, 1);
        cyc(0, 0, 1, 2, 9, 1, 0, 0, 1);
        cyc(0, 1, 1, 2, 9, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("flush_busy", bus.busy_valid, 0);

        // FPU with a 5-cycle hold; fpu_stall drops during the hold
        cyc(0, 0, 1, 3, 17, 1, 0, 0, 1);
        cyc(0, 0, 1, 3, 17, 1, 0, 0, 1);
        cyc(1, 0, 1, 3, 17, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 3, 17, 1, 0, 0, 0);
        n_wb = 0;
        cyc(0, 0, 1, 3, 17, 1, 0, 0, 0);
        cyc(0, 0, 1, 3, 17, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("fpu_hold_wb", n_wb, 1);

        // two MUL ops back to back with issue_valid held
        n_mul_start = 0; n_wb = 0;
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1, 3, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 3, 1, 1, 0, 1);
        check("b2b_starts", n_mul_start, 2);
        check("b2b_wb", n_wb, 2);

        // divider never ready: watchdog
        n_wb = 0;
        cyc(0, 0, 1, 2, 7, 1, 0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("timeout_wb", n_wb, 1);
        check("timeout_set", bus.timeout_err, 1);
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("timeout_sticky", bus.timeout_err, 1);

        // asynchronous reset between edges while in WAIT_FPU
        cyc(0, 0, 1, 3, 21, 1, 0, 0, 1);
        cyc(0, 0, 1, 3, 21, 1, 0, 0, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        drive_idle();
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 0, 1, 0, 4, 1, 0, 0, 1);
        check("alu_no_stall", bus.ex_stall, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        check("stall_saturated", bus.stall_cycles, SAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
